sd_decim_ctrl: RTL and testbench

Sequencing controller for the sigma-delta modulator / Sinc3 decimation chain. It generates the shared sample-enable strobe that clocks the modulators and the Sinc3 filter, and counts oversampling periods. It discards the Sinc3 start-up transient, captures each decimated filter output and presents it downstream over a valid/ready handshake. Configuration of the rate divider and OSR is applied only while idle.

---
 rtl/sd_pkg.sv | 14 +
 rtl/sd_clk_div.sv | 35 +++
 rtl/sd_decim_ctrl.sv | 156 +++++++++++++++
 tb/tb_sd_decim_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and defaults for the sigma-delta decimation controller
package sd_pkg;

  // Controller states: no strobes / strobes with discarded outputs / strobes with captured outputs
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } sdState_t;

  // Sinc3 start-up transient lasts three decimated periods
  localparam int SETTLE_COUNT = 3;

endpackage

// File: rtl/sd_clk_div.sv
// rtl/sd_clk_div.sv - programmable enable divider producing the shared sample strobe
//
// Ports:
//   clk    system clock
//   rst    synchronous active-low reset
//   run    divider counts while high; strobe is forced low otherwise
//   clr    synchronous clear of the divide counter
//   div    strobe period is div+1 clocks
//   sd_en  one-cycle strobe when the counter reaches div
module sd_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sd_en
);

  logic [DIV_WIDTH-1:0] div_cnt;

  assign sd_en = run && (div_cnt == div);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= sd_en ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_decim_ctrl.sv
// rtl/sd_decim_ctrl.sv - sequencing controller for the sigma-delta / Sinc3 decimation chain
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   cfgValid/cfgDiv/cfgOsr  configuration write (accepted only in IDLE with cfgOsr != 0)
//   cfgErr              one-cycle pulse after a rejected configuration write
//   start, stop         begin / end a conversion run
//   sdEn                shared strobe to the modulators and Sinc3
//   filtIn              Sinc3 output
//   outData/outValid/outReady  decimated sample handshake
//   busy                state is not IDLE
//   overrun             sticky: a sample was dropped because downstream stalled
module sd_decim_ctrl
  import sd_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int OSR_WIDTH = 8,
  parameter int WIDTH     = 16,
  parameter int SETTLE    = SETTLE_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfgValid,
  input  logic [DIV_WIDTH-1:0] cfgDiv,
  input  logic [OSR_WIDTH-1:0] cfgOsr,
  output logic                 cfgErr,
  input  logic                 start,
  input  logic                 stop,
  output logic                 sdEn,
  input  logic [WIDTH-1:0]     filtIn,
  output logic [WIDTH-1:0]     outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy,
  output logic                 overrun
);

  // Index of the last discarded event; unused when SETTLE is 0
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);

  sdState_t             state, state_nxt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [OSR_WIDTH-1:0] osr_q;
  logic [OSR_WIDTH-1:0] osr_cnt;
  logic [7:0]           set_cnt;
  logic                 go;
  logic                 evt;
  logic                 evt_d1;
  logic                 capture_en;
  logic                 settle_evt;
  logic                 cfg_ok;

  assign go     = (state == sd_pkg::IDLE) && start;
  assign evt    = sdEn && (osr_cnt == osr_q - 1'b1);
  assign cfg_ok = (state == sd_pkg::IDLE) && (cfgOsr != '0);

  sd_clk_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .run  (busy),
    .clr  (go),
    .div  (div_q),
    .sd_en(sdEn)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= sd_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; stop wins over a coincident decimation event
  always_comb begin
    state_nxt = state;
    unique case (state)
      sd_pkg::IDLE: begin
        if (start) state_nxt = (SETTLE == 0) ? sd_pkg::RUN : sd_pkg::SETTLE;
      end
      sd_pkg::SETTLE: begin
        if (stop)                                  state_nxt = sd_pkg::IDLE;
        else if (evt && (set_cnt == SET_LAST))     state_nxt = sd_pkg::RUN;
      end
      sd_pkg::RUN: begin
        if (stop) state_nxt = sd_pkg::IDLE;
      end
      default: state_nxt = sd_pkg::IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state != sd_pkg::IDLE);
    capture_en = (state == sd_pkg::RUN) && evt && !stop;
    settle_evt = (state == sd_pkg::SETTLE) && evt && !stop;
  end

  // Configuration registers and reject pulse; cfg written with start lands before the first strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      osr_q  <= OSR_WIDTH'(1);
      cfgErr <= 1'b0;
    end else begin
      cfgErr <= cfgValid && !cfg_ok;
      if (cfgValid && cfg_ok) begin
        div_q <= cfgDiv;
        osr_q <= cfgOsr;
      end
    end
  end

  // OSR and settle counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      osr_cnt <= '0;
      set_cnt <= '0;
      evt_d1  <= 1'b0;
    end else begin
      evt_d1 <= capture_en;
      if (go) begin
        osr_cnt <= '0;
        set_cnt <= '0;
      end else begin
        if (sdEn) osr_cnt <= evt ? '0 : osr_cnt + 1'b1;
        if (settle_evt) set_cnt <= set_cnt + 1'b1;
      end
    end
  end

  // Capture one cycle after the event, since Sinc3 registers its output on the strobe edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      outData  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (evt_d1) begin
        if (outValid && !outReady) begin
          overrun <= 1'b1;
        end else begin
          outData  <= filtIn;
          outValid <= 1'b1;
        end
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
      if (go) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_decim_ctrl.sv
// tb/tb_sd_decim_ctrl.sv - self-checking bench for sd_decim_ctrl
module tb_sd_decim_ctrl;

  localparam int SETTLE_N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgValid;
  logic [7:0]  cfgDiv;
  logic [7:0]  cfgOsr;
  logic        cfgErr;
  logic        start;
  logic        stop;
  logic        sdEn;
  logic [15:0] filtIn;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic        busy;
  logic        overrun;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] fin [0:4095];
  bit          v_m;
  bit          ov_m;
  bit          rdy_prev;
  logic [15:0] d_m;
  int          rd;
  int          ro;

  sd_decim_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .cfgValid(cfgValid),
    .cfgDiv  (cfgDiv),
    .cfgOsr  (cfgOsr),
    .cfgErr  (cfgErr),
    .start   (start),
    .stop    (stop),
    .sdEn    (sdEn),
    .filtIn  (filtIn),
    .outData (outData),
    .outValid(outValid),
    .outReady(outReady),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe expected in cycle c for a run whose start was driven in cycle ks
  function automatic bit exp_sd(input int c, input int ks, input int div);
    int sdx;
    sdx = c - ks - 1 - div;
    return (sdx >= 0) && ((sdx % (div + 1)) == 0);
  endfunction

  // Cycle e holds a decimation event that falls after the settle period
  function automatic bit captured(input int e, input int ks, input int div, input int osr);
    int sdx;
    int idx;
    sdx = e - ks - 1 - div;
    if (sdx < 0 || (sdx % (div + 1)) != 0) return 1'b0;
    idx = sdx / (div + 1) + 1;
    return ((idx % osr) == 0) && ((idx / osr) > SETTLE_N);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sdEn"},     32'(sdEn),     32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_outValid"}, 32'(outValid), 32'd0);
    chk({tag, "_outData"},  32'(outData),  32'd0);
    chk({tag, "_overrun"},  32'(overrun),  32'd0);
    chk({tag, "_cfgErr"},   32'(cfgErr),   32'd0);
  endtask

  // Start was driven in the current cycle; rdy_mode 0=ready, 1=stalled, 2=random
  task automatic run(input int div, input int osr, input int ncyc, input int cfg_at,
                     input int rdy_mode, input bit do_stop);
    int ks;
    int c;
    ks = cyc;
    ov_m = 1'b0;
    outReady = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    rdy_prev = outReady;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(negedge clk);
      c = cyc;
      if (captured(c - 2, ks, div, osr)) begin
        if (v_m && !rdy_prev) ov_m = 1'b1;
        else begin
          d_m = fin[c - 1];
          v_m = 1'b1;
        end
      end else if (v_m && rdy_prev) begin
        v_m = 1'b0;
      end
      chk("busy",     32'(busy),     32'd1);
      chk("sdEn",     32'(sdEn),     32'(exp_sd(c, ks, div)));
      chk("cfgErr",   32'(cfgErr),   32'(rel == cfg_at + 1));
      chk("outValid", 32'(outValid), 32'(v_m));
      chk("outData",  32'(outData),  32'(d_m));
      chk("overrun",  32'(overrun),  32'(ov_m));
      start    = 1'b0;
      cfgValid = (rel == cfg_at);
      cfgDiv   = 8'd0;
      cfgOsr   = 8'd1;
      stop     = do_stop && (rel == ncyc);
      filtIn   = 16'($urandom);
      fin[c]   = filtIn;
      outReady = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      rdy_prev = outReady;
    end
  endtask

  task automatic check_stopped(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sdEn"}, 32'(sdEn), 32'd0);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfgValid = 1'b0; cfgDiv = 8'd0; cfgOsr = 8'd1;
    start = 1'b0; stop = 1'b0; filtIn = 16'd0; outReady = 1'b0;
    v_m = 1'b0; ov_m = 1'b0; d_m = 16'd0; rdy_prev = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // div=0, osr=32, configuration applied together with start
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'd0; cfgOsr = 8'd32; start = 1'b1;
    run(0, 32, 200, -1, 0, 1'b1);
    check_stopped("s1_stop");

    // div=3, osr=4 configured in a separate idle cycle
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'd3; cfgOsr = 8'd4;
    @(negedge clk);
    chk("s2_cfg_accept", 32'(cfgErr), 32'd0);
    cfgValid = 1'b0; start = 1'b1;
    run(3, 4, 100, -1, 0, 1'b1);
    check_stopped("s2_stop");

    // osr=0 rejected in idle, then a write during RUN rejected; rate stays div=3/osr=4
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'd7; cfgOsr = 8'd0;
    @(negedge clk);
    chk("rej_idle_pulse", 32'(cfgErr), 32'd1);
    cfgValid = 1'b0;
    @(negedge clk);
    chk("rej_idle_end", 32'(cfgErr), 32'd0);
    start = 1'b1;
    run(3, 4, 70, 67, 0, 1'b1);
    check_stopped("s4_stop");

    // stalled downstream across two events
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'd0; cfgOsr = 8'd4;
    @(negedge clk);
    cfgValid = 1'b0; start = 1'b1;
    run(0, 4, 23, -1, 1, 1'b1);
    @(negedge clk);
    chk("ovr_stop_busy",  32'(busy),     32'd0);
    chk("ovr_held_valid", 32'(outValid), 32'd1);
    chk("ovr_held_data",  32'(outData),  32'(d_m));
    chk("ovr_sticky",     32'(overrun),  32'd1);
    stop = 1'b0; outReady = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", 32'(outValid), 32'd0);
    chk("ovr_drain_sticky", 32'(overrun), 32'd1);
    v_m = 1'b0;

    // stop coincides with a captured decimation event (div=1, osr=2: event at rel 20)
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'd1; cfgOsr = 8'd2;
    @(negedge clk);
    cfgValid = 1'b0; start = 1'b1;
    run(1, 2, 20, -1, 0, 1'b1);
    @(negedge clk);
    chk("stopevt_busy",    32'(busy),    32'd0);
    chk("stopevt_sdEn",    32'(sdEn),    32'd0);
    chk("stopevt_overrun", 32'(overrun), 32'd0);
    stop = 1'b0;
    @(negedge clk);
    chk("stopevt_nocapture", 32'(outValid), 32'd0);

    // randomized rate and randomized downstream readiness
    rd = $urandom_range(0, 3);
    ro = $urandom_range(1, 6);
    @(negedge clk);
    cfgValid = 1'b1; cfgDiv = 8'(rd); cfgOsr = 8'(ro); start = 1'b1;
    run(rd, ro, 150, -1, 2, 1'b1);
    check_stopped("rand_stop");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    v_m = 1'b0; ov_m = 1'b0; d_m = 16'd0;

    // reset mid-RUN with a pending sample; default config div=0, osr=1
    @(negedge clk);
    start = 1'b1;
    run(0, 1, 8, -1, 1, 1'b0);
    chk("midrst_pending", 32'(outValid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
